instr_sequencer: RTL and testbench
==================================

// Module: instr_sequencer
// PURPOSE
//  Control FSM for the 8-bit datapath. Fetches opcode and operand bytes over a req/ack memory port.
//  Decodes instructions_e (NOP, LDX, AOP) and drives one control_word_t per cycle to the
//  ALU, register file and address unit. Sits between memory interface and datapath; sole driver of ctrl_word.
// PARAMETERS
//  DATA_W   8   data bus / instruction byte width
//  ADDR_W   9   address bus width (informational; sequencer only selects the address source)
// PORTS
//  clk         in   1        single clock, all state on rising edge
//  rst_n       in   1        asynchronous, active-low reset
//  run         in   1        level; leaves HALT when high
//  halt_req    in   1        request halt at next instruction boundary
//  mem_rdata   in   DATA_W   read data, valid in the cycle mem_ack=1
//  mem_ack     in   1        memory completed current request
//  alu_flags   in   2        alu_flag_t {alu_zero, alu_carry}, registered into flags_q on ALU writeback
//  mem_req     out  1        memory request, held until mem_ack
//  addr_src    out  1        address_source_sel_e; CONTROL_ADDRESS for all fetches
//  pc_inc      out  1        1-cycle pulse: increment PC after each accepted fetch
//  ctrl_word   out  $bits(control_word_t)  datapath control word
//  flags_q     out  2        last captured ALU flags
//  halted      out  1        1 while in HALT
//  illegal     out  1        sticky: undefined opcode seen; cleared only by reset
// BEHAVIOUR
//  Encoding: byte0[7:4]=instructions_e, byte0[3:0]=operand nibble.
//   LDX: byte0[2:0]=dest register_sel_e; byte1=immediate, written to dest.
//   AOP: byte0[3:0]=alu_op_e; byte1[6:4]=reg1 (also dest), byte1[2:0]=reg2.
//  Default ctrl_word (any cycle not listed): alu_op=ALUNOP, memory_op=READ, all sel=REG_A,
//   SelInSource=ALU, reset=halt=control_unit_load=next_instr=0. control_unit_load=register write strobe.
//  Reset (async): state=RST, mem_req=pc_inc=halted=illegal=0, flags_q=0, ctrl_word=default.
//  States / transitions:
//   RST   : 1 cycle after rst_n rises, ctrl_word.reset=1 -> FETCH
//   FETCH : mem_req=1, addr_src=CONTROL_ADDRESS. mem_ack=0 -> stay. mem_ack=1 -> IR<=mem_rdata, pc_inc=1 -> DECODE
//   DECODE: NOP -> next_instr=1 -> FETCH (or HALT if halt_req)
//           LDX/AOP -> OPER. Opcode >2 or AOP alu_op >NOT -> illegal<=1 -> HALT
//   OPER  : same handshake as FETCH; OP<=mem_rdata, pc_inc=1 on ack -> EXEC
//   EXEC  : LDX: SelInSource=BUS, ControlSelInxD=dest, control_unit_load=1; datapath bus carries OP
//           AOP: alu_op, Reg1xD=reg1, Reg2xD=reg2, InxD=reg1, SelInSource=ALU,
//                control_unit_load=1, flags_q<=alu_flags
//           next_instr=1 -> FETCH, or HALT if halt_req=1 this cycle
//   HALT  : ctrl_word.halt=1, halted=1, mem_req=0. run=1 -> FETCH (same edge). run wins over halt_req.
//  Latency: NOP 2 cycles, LDX/AOP 4 cycles, all at zero-wait memory (ack in req cycle). +1 cycle per wait cycle.
//  mem_req never drops before ack. No new request issues in the ack cycle.
//  halt_req ignored mid-instruction; sampled only in DECODE(NOP) and EXEC.
//  Reset mid-fetch: request abandoned, mem_req=0 asynchronously; no pc_inc.
//  pc_inc and next_instr never asserted in RST or HALT.
// STRUCTURE
//  controlpack additions: seq_state_e {RST,FETCH,DECODE,OPER,EXEC,HALT};
//   aop_operand_t packed {logic pad1; register_sel_e reg1; logic pad0; register_sel_e reg2}.
//  Sub-module seq_decode (combinational): IR,OP,state -> control_word_t, illegal_op.
//  instr_sequencer holds FSM, IR/OP, flags_q, sticky illegal.
// TESTING
//  1 reset then run=1, mem 0x00 ack-in-cycle -> reset=1 one cycle; pc_inc at fetch; next_instr 2 cycles later
//  2 LDX: 0x11,0x5A zero-wait -> EXEC: InxD=REG_B, SelInSource=BUS, load=1; 2 pc_inc pulses; 4 cycles
//  3 AOP ADD: 0x22,0x01, alu_flags=2'b01 -> alu_op=ADD, Reg1=REG_A, Reg2=REG_B, InxD=REG_A; flags_q=01
//  4 opcode 0x70 -> illegal=1, halted=1, halt=1 held; run=1 -> FETCH; illegal remains 1
//  5 ack delayed 3 cycles on both LDX bytes -> mem_req stable 4 cycles each; 10-cycle instruction
//  6 rst_n low in OPER with mem_req=1 -> mem_req=0 immediately; after release RST then FETCH; no pc_inc

Source files
------------

// File: rtl/instr_sequencer_pkg.sv
// Shared types for the instruction sequencer: opcodes, register/ALU selects,
// the datapath control word and the sequencer state encoding.
package instr_sequencer_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 9;

  typedef enum logic [3:0] {NOP = 4'd0, LDX = 4'd1, AOP = 4'd2} instructions_e;

  typedef enum logic [2:0] {
    REG_A, REG_B, REG_C, REG_D, REG_E, REG_F, REG_G, REG_H
  } register_sel_e;

  typedef enum logic [3:0] {
    ALUNOP, PASS, ADD, SUB, AND, OR, XOR, NOT
  } alu_op_e;

  typedef enum logic {READ, WRITE} memory_op_e;
  typedef enum logic {ALU, BUS} sel_in_source_e;
  typedef enum logic {CONTROL_ADDRESS, DATA_ADDRESS} address_source_sel_e;

  typedef struct packed {
    logic alu_zero;
    logic alu_carry;
  } alu_flag_t;

  typedef struct packed {
    alu_op_e        alu_op;
    memory_op_e     memory_op;
    register_sel_e  reg1_sel;
    register_sel_e  reg2_sel;
    register_sel_e  in_sel;
    sel_in_source_e sel_in_source;
    logic           reset;
    logic           halt;
    logic           control_unit_load;
    logic           next_instr;
  } control_word_t;

  typedef enum logic [2:0] {RST, FETCH, DECODE, OPER, EXEC, HALT} seq_state_e;

  typedef struct packed {
    logic          pad1;
    register_sel_e reg1;
    logic          pad0;
    register_sel_e reg2;
  } aop_operand_t;

  localparam control_word_t CTRL_DEFAULT = '{
    alu_op: ALUNOP, memory_op: READ, reg1_sel: REG_A, reg2_sel: REG_A,
    in_sel: REG_A, sel_in_source: ALU, reset: 1'b0, halt: 1'b0,
    control_unit_load: 1'b0, next_instr: 1'b0
  };

  // Undefined opcode, or an ALU operation beyond NOT.
  function automatic logic is_illegal(input logic [7:0] ir);
    return (ir[7:4] > 4'(AOP)) ||
           ((ir[7:4] == 4'(AOP)) && (ir[3:0] > 4'(NOT)));
  endfunction

endpackage

// File: rtl/instr_sequencer_decode.sv
// Combinational decode: turns the latched instruction bytes and the current
// sequencer state into the datapath control word.
module seq_decode
  import instr_sequencer_pkg::*;
(
  input  logic [7:0]    ir,
  input  logic [7:0]    op,
  input  seq_state_e    state,
  output control_word_t ctrl_word,
  output logic          illegal_op
);

  instructions_e opcode;
  aop_operand_t  operand;
  logic          unused_pad;

  assign opcode     = instructions_e'(ir[7:4]);
  assign operand    = aop_operand_t'(op);
  assign unused_pad = operand.pad1 ^ operand.pad0;
  assign illegal_op = is_illegal(ir);

  always_comb begin
    ctrl_word = CTRL_DEFAULT;
    case (state)
      RST:    ctrl_word.reset = 1'b1;
      DECODE: ctrl_word.next_instr = (opcode == NOP);
      EXEC: begin
        ctrl_word.next_instr = 1'b1;
        if (opcode == LDX) begin
          // Immediate arrives on the datapath bus and is written to dest.
          ctrl_word.sel_in_source     = BUS;
          ctrl_word.in_sel            = register_sel_e'(ir[2:0]);
          ctrl_word.control_unit_load = 1'b1;
        end else if (opcode == AOP) begin
          ctrl_word.alu_op            = alu_op_e'(ir[3:0]);
          ctrl_word.reg1_sel          = operand.reg1;
          ctrl_word.reg2_sel          = operand.reg2;
          ctrl_word.in_sel            = operand.reg1;
          ctrl_word.sel_in_source     = ALU;
          ctrl_word.control_unit_load = 1'b1;
        end
      end
      HALT:    ctrl_word.halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches opcode/operand bytes over a req/ack port and
// steps the datapath through decode and execute with one control word per cycle.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic                halt_req,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  input  alu_flag_t           alu_flags,
  output logic                mem_req,
  output address_source_sel_e addr_src,
  output logic                pc_inc,
  output control_word_t       ctrl_word,
  output alu_flag_t           flags_q,
  output logic                halted,
  output logic                illegal
);

  seq_state_e        state_reg, state_next;
  logic [DATA_W-1:0] ir_reg, op_reg;
  control_word_t     dec_word;
  logic              illegal_op;

  seq_decode u_decode (
    .ir        (ir_reg[7:0]),
    .op        (op_reg[7:0]),
    .state     (state_reg),
    .ctrl_word (dec_word),
    .illegal_op(illegal_op)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RST;
      ir_reg    <= '0;
      op_reg    <= '0;
      flags_q   <= '0;
      illegal   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == FETCH && mem_ack) ir_reg <= mem_rdata;
      if (state_reg == OPER && mem_ack)  op_reg <= mem_rdata;
      if (state_reg == EXEC && ir_reg[7:4] == 4'(AOP)) flags_q <= alu_flags;
      if (state_reg == DECODE && illegal_op) illegal <= 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    mem_req    = 1'b0;
    pc_inc     = 1'b0;
    addr_src   = DATA_ADDRESS;
    halted     = 1'b0;
    case (state_reg)
      RST: state_next = FETCH;
      FETCH, OPER: begin
        mem_req  = 1'b1;
        addr_src = CONTROL_ADDRESS;
        if (mem_ack) begin
          pc_inc     = 1'b1;
          state_next = (state_reg == FETCH) ? DECODE : EXEC;
        end
      end
      DECODE: begin
        if (illegal_op)                     state_next = HALT;
        else if (ir_reg[7:4] == 4'(NOP))    state_next = halt_req ? HALT : FETCH;
        else                                state_next = OPER;
      end
      EXEC: state_next = halt_req ? HALT : FETCH;
      HALT: begin
        halted = 1'b1;
        if (run) state_next = FETCH;
      end
      default: state_next = RST;
    endcase
  end

  // The reset strobe only appears in the cycle after rst_n is released.
  always_comb begin
    ctrl_word       = dec_word;
    ctrl_word.reset = dec_word.reset & rst_n;
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Vector-driven bench: each instruction is expanded into per-cycle records of
// inputs and expected outputs, then all records are applied and compared.
module tb_instr_sequencer;
  import instr_sequencer_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                run = 1'b0;
  logic                halt_req = 1'b0;
  logic [7:0]          mem_rdata = 8'h00;
  logic                mem_ack = 1'b0;
  alu_flag_t           alu_flags = '0;
  logic                mem_req;
  address_source_sel_e addr_src;
  logic                pc_inc;
  control_word_t       ctrl_word;
  alu_flag_t           flags_q;
  logic                halted;
  logic                illegal;

  always #5 clk = ~clk;

  instr_sequencer #(.DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .halt_req(halt_req),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .alu_flags(alu_flags),
    .mem_req(mem_req), .addr_src(addr_src), .pc_inc(pc_inc),
    .ctrl_word(ctrl_word), .flags_q(flags_q), .halted(halted), .illegal(illegal)
  );

  typedef struct {
    logic          rst_n, run, halt_req, ack;
    logic [7:0]    rdata;
    logic [1:0]    flags_in;
    logic          e_mem_req, e_pc_inc, e_halted, e_illegal;
    logic [1:0]    e_flags;
    control_word_t e_cw;
    int            instr;
  } vec_t;

  vec_t       vq[$];
  int         errors = 0;
  int         checks = 0;
  int         instr_id = 0;
  logic       cur_hreq = 1'b0;
  logic       m_illegal = 1'b0;
  logic [1:0] m_flags = 2'b00;

  function automatic control_word_t cw_idle();
    control_word_t c;
    c.alu_op = ALUNOP; c.memory_op = READ;
    c.reg1_sel = REG_A; c.reg2_sel = REG_A; c.in_sel = REG_A;
    c.sel_in_source = ALU; c.reset = 1'b0; c.halt = 1'b0;
    c.control_unit_load = 1'b0; c.next_instr = 1'b0;
    return c;
  endfunction

  function automatic vec_t base_vec();
    vec_t v;
    v.rst_n = 1'b1; v.run = 1'b0; v.halt_req = cur_hreq; v.ack = 1'b0;
    v.rdata = 8'($urandom); v.flags_in = 2'($urandom);
    v.e_mem_req = 1'b0; v.e_pc_inc = 1'b0; v.e_halted = 1'b0;
    v.e_illegal = m_illegal; v.e_flags = m_flags; v.e_cw = cw_idle();
    v.instr = instr_id;
    return v;
  endfunction

  // n cycles held in reset, then the release cycle carrying the reset strobe.
  task automatic push_reset(input int n, input logic ack_during);
    vec_t v;
    instr_id++;
    m_illegal = 1'b0;
    m_flags   = 2'b00;
    for (int i = 0; i < n; i++) begin
      v = base_vec(); v.rst_n = 1'b0; v.ack = ack_during;
      vq.push_back(v);
    end
    v = base_vec(); v.e_cw.reset = 1'b1;
    vq.push_back(v);
  endtask

  task automatic push_fetch(input logic [7:0] b, input int waits);
    vec_t v;
    for (int i = 0; i < waits; i++) begin
      v = base_vec(); v.e_mem_req = 1'b1;
      vq.push_back(v);
    end
    v = base_vec(); v.ack = 1'b1; v.rdata = b; v.e_mem_req = 1'b1; v.e_pc_inc = 1'b1;
    vq.push_back(v);
  endtask

  // Returns 1 when the instruction ends in HALT.
  task automatic push_instr(input logic [7:0] b0, input logic [7:0] b1, input int w0,
                            input int w1, input logic hreq, input logic [1:0] fl,
                            output logic to_halt);
    vec_t       v;
    logic [3:0] opc, lo;
    instr_id++;
    cur_hreq = hreq;
    opc = b0[7:4];
    lo  = b0[3:0];
    push_fetch(b0, w0);
    v = base_vec();
    if (opc > 4'd2 || (opc == 4'd2 && lo > 4'd7)) begin
      vq.push_back(v);
      m_illegal = 1'b1;
      to_halt = 1'b1;
    end else if (opc == 4'd0) begin
      v.e_cw.next_instr = 1'b1;
      vq.push_back(v);
      to_halt = hreq;
    end else begin
      vq.push_back(v);
      push_fetch(b1, w1);
      v = base_vec();
      v.flags_in = fl;
      v.e_cw.next_instr = 1'b1;
      v.e_cw.control_unit_load = 1'b1;
      if (opc == 4'd1) begin
        v.e_cw.sel_in_source = BUS;
        v.e_cw.in_sel = register_sel_e'(b0[2:0]);
      end else begin
        v.e_cw.alu_op   = alu_op_e'(lo);
        v.e_cw.reg1_sel = register_sel_e'(b1[6:4]);
        v.e_cw.reg2_sel = register_sel_e'(b1[2:0]);
        v.e_cw.in_sel   = register_sel_e'(b1[6:4]);
      end
      vq.push_back(v);
      if (opc == 4'd2) m_flags = fl;
      to_halt = hreq;
    end
    cur_hreq = 1'b0;
  endtask

  // k idle HALT cycles, then run=1 (halt_req may also be high; run wins).
  task automatic push_halt(input int k);
    vec_t v;
    for (int i = 0; i <= k; i++) begin
      v = base_vec();
      v.halt_req = 1'($urandom_range(0, 1));
      v.run = (i == k);
      v.e_halted = 1'b1;
      v.e_cw.halt = 1'b1;
      vq.push_back(v);
    end
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s vec=%0d instr=%0d got=%h want=%h", name, idx, vq[idx].instr, got, want);
    end
  endtask

  task automatic do_instr(input logic [7:0] b0, input logic [7:0] b1, input int w0,
                          input int w1, input logic hreq, input logic [1:0] fl,
                          input int hk);
    logic h;
    push_instr(b0, b1, w0, w1, hreq, fl, h);
    if (h) push_halt(hk);
  endtask

  initial begin
    vec_t v;
    int   last;
    logic [7:0] b0, b1;
    int   kind;

    // Directed scenarios.
    push_reset(3, 1'b0);
    do_instr(8'h00, 8'h00, 0, 0, 1'b0, 2'b00, 0);   // NOP
    do_instr(8'h11, 8'h5A, 0, 0, 1'b0, 2'b00, 0);   // LDX B, 0x5A
    do_instr(8'h22, 8'h01, 0, 0, 1'b0, 2'b01, 0);   // AOP ADD A, B
    do_instr(8'h70, 8'h00, 0, 0, 1'b0, 2'b00, 3);   // illegal opcode
    do_instr(8'h00, 8'h00, 0, 0, 1'b0, 2'b00, 0);   // illegal stays set
    do_instr(8'h2F, 8'h00, 1, 0, 1'b0, 2'b00, 1);   // ALU op beyond NOT
    do_instr(8'h13, 8'hC3, 3, 3, 1'b0, 2'b00, 0);   // 10-cycle LDX
    do_instr(8'h00, 8'h00, 0, 0, 1'b1, 2'b00, 2);   // NOP with halt_req
    do_instr(8'h27, 8'h76, 1, 2, 1'b1, 2'b10, 0);   // AOP NOT with halt_req

    // Reset while the operand request is outstanding.
    instr_id++;
    push_fetch(8'h13, 0);
    v = base_vec(); vq.push_back(v);
    for (int i = 0; i < 2; i++) begin
      v = base_vec(); v.e_mem_req = 1'b1; vq.push_back(v);
    end
    push_reset(2, 1'b1);
    do_instr(8'h00, 8'h00, 0, 0, 1'b0, 2'b00, 0);

    // Randomized legal programs.
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 2);
      b1 = 8'($urandom);
      if (kind == 0)      b0 = {4'h0, 4'($urandom)};
      else if (kind == 1) b0 = {4'h1, 4'($urandom)};
      else                b0 = {4'h2, 1'b0, 3'($urandom)};
      do_instr(b0, b1, $urandom_range(0, 3), $urandom_range(0, 3),
               ($urandom_range(0, 4) == 0), 2'($urandom), $urandom_range(0, 3));
    end

    last = -1;
    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      @(negedge clk);
      rst_n = v.rst_n; run = v.run; halt_req = v.halt_req;
      mem_ack = v.ack; mem_rdata = v.rdata; alu_flags = alu_flag_t'(v.flags_in);
      #1;
      if (v.instr != last) begin
        $display("instr %0d starts at vec %0d", v.instr, i);
        last = v.instr;
      end
      chk("mem_req",   i, 32'(mem_req),   32'(v.e_mem_req));
      chk("pc_inc",    i, 32'(pc_inc),    32'(v.e_pc_inc));
      chk("halted",    i, 32'(halted),    32'(v.e_halted));
      chk("illegal",   i, 32'(illegal),   32'(v.e_illegal));
      chk("flags_q",   i, 32'(flags_q),   32'(v.e_flags));
      chk("ctrl_word", i, 32'(ctrl_word), 32'(v.e_cw));
      if (v.e_mem_req) chk("addr_src", i, 32'(addr_src), 32'(CONTROL_ADDRESS));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
